hwpe_stream_ctrl_fsm: RTL and testbench

Parametrised HWPE control FSM sequencing N_IN source streamers, N_OUT sink streamers, one engine and the ucode loop (uloop) index generator. Generalises the fixed 3-in/1-out controller to arbitrary stream counts. Adds multi-iteration execution (COMPUTE -> UPDATEIDX -> relaunch until ucode done), iteration counting, a busy flag and an optional watchdog. Sits between the hwpe_ctrl slave/regfile and the streamer/engine.

---
 rtl/hwpe_stream_ctrl_fsm.sv | 193 +++++++++++++++++++
 tb/tb_hwpe_stream_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_ctrl_fsm.sv
// HWPE stream control FSM: sequences N_IN sources, N_OUT sinks, engine and uloop.
// Optional watchdog abort enabled by defining HWPE_FSM_WATCHDOG_EN.
module hwpe_stream_ctrl_fsm #(
   parameter int unsigned N_IN        = 3,
   parameter int unsigned N_OUT       = 1,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned ITER_W      = 16,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic [N_IN-1:0]   in_ready_start_i,
   input  logic [N_OUT-1:0]  out_ready_start_i,
   output logic [N_IN-1:0]   in_req_start_o,
   output logic [N_OUT-1:0]  out_req_start_o,
   input  logic              engine_ready_i,
   input  logic [CNT_W-1:0]  engine_cnt_i,
   input  logic [CNT_W-1:0]  cnt_limit_i,
   output logic              engine_start_o,
   output logic              engine_clear_o,
   output logic              engine_enable_o,
   input  logic              ucode_valid_i,
   input  logic              ucode_done_i,
   output logic              ucode_enable_o,
   output logic              ucode_clear_o,
   output logic              done_o,
   output logic              busy_o,
   output logic [ITER_W-1:0] iter_cnt_o,
   output logic              error_o
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      COMPUTE,
      UPDATEIDX,
      TERMINATE
   } state_t;

   state_t             state_q, state_d;
   logic [ITER_W-1:0]  iter_q;
   logic               launched_q;
   logic               all_ready;
   logic               launch;
   logic               timeout;
   logic               iter_hit;

   assign all_ready = (&in_ready_start_i) & (&out_ready_start_i);
   assign iter_hit  = (engine_cnt_i == cnt_limit_i);
   assign busy_o     = (state_q != IDLE);
   assign iter_cnt_o = iter_q;

`ifdef HWPE_FSM_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q;
   logic            wd_state;

   assign wd_state = (state_q == WAIT) || (state_q == UPDATEIDX) ||
                     (state_q == TERMINATE);
   assign timeout  = wd_state && (wd_q == WD_W'(TIMEOUT_CYC));

   // Watchdog counts dwell time in the waiting states, restarts on any move
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q <= '0;
      end else if (clear_i || !wd_state || (state_d != state_q)) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Iteration counter: cleared at job start, saturating increment per iteration
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iter_q <= '0;
      end else if (clear_i) begin
         iter_q <= '0;
      end else if ((state_q == IDLE) && start_i) begin
         iter_q <= '0;
      end else if ((state_q == COMPUTE) && iter_hit && (iter_q != '1)) begin
         iter_q <= iter_q + 1'b1;
      end
   end

   // Marks that the single uloop step of this UPDATEIDX visit was issued
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         launched_q <= 1'b0;
      end else if (clear_i) begin
         launched_q <= 1'b0;
      end else begin
         launched_q <= (state_q == UPDATEIDX) && (state_d == UPDATEIDX);
      end
   end

   // Next-state and output decode; launch is a Mealy overlay on the state
   always_comb begin
      state_d         = state_q;
      launch          = 1'b0;
      in_req_start_o  = '0;
      out_req_start_o = '0;
      engine_start_o  = 1'b0;
      engine_clear_o  = 1'b0;
      engine_enable_o = 1'b1;
      ucode_enable_o  = 1'b0;
      ucode_clear_o   = 1'b0;
      done_o          = 1'b0;
      error_o         = 1'b0;
      unique case (state_q)
         IDLE: begin
            engine_clear_o  = 1'b1;
            ucode_clear_o   = 1'b1;
            engine_enable_o = 1'b0;
            if (start_i) state_d = START;
         end
         START: begin
            if (all_ready) launch = 1'b1;
            else           state_d = WAIT;
         end
         WAIT: begin
            engine_enable_o = 1'b0;
            if (timeout) begin
               state_d = IDLE;
               error_o = 1'b1;
            end else if (all_ready) begin
               launch = 1'b1;
            end
         end
         COMPUTE: begin
            engine_start_o = engine_ready_i;
            if (iter_hit) state_d = UPDATEIDX;
         end
         UPDATEIDX: begin
            engine_clear_o = 1'b1;
            if (timeout) begin
               state_d = IDLE;
               error_o = 1'b1;
            end else if (!launched_q) begin
               ucode_enable_o = 1'b1;
            end else if (ucode_valid_i) begin
               if (ucode_done_i)   state_d = TERMINATE;
               else if (all_ready) launch  = 1'b1;
               else                state_d = WAIT;
            end
         end
         TERMINATE: begin
            engine_enable_o = 1'b0;
            if (timeout) begin
               state_d = IDLE;
               error_o = 1'b1;
            end else if (all_ready) begin
               state_d = IDLE;
               done_o  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (launch) begin
         state_d         = COMPUTE;
         in_req_start_o  = '1;
         out_req_start_o = '1;
         engine_start_o  = 1'b1;
         engine_clear_o  = 1'b0;
         engine_enable_o = 1'b1;
      end
      if (clear_i) begin
         state_d         = IDLE;
         in_req_start_o  = '0;
         out_req_start_o = '0;
         engine_start_o  = 1'b0;
         ucode_enable_o  = 1'b0;
         done_o          = 1'b0;
         error_o         = 1'b0;
      end
   end

endmodule

// File: tb/tb_hwpe_stream_ctrl_fsm.sv
// Directed table-driven bench for hwpe_stream_ctrl_fsm.
// Define HWPE_FSM_WATCHDOG_EN to also exercise the watchdog abort.
module tb_hwpe_stream_ctrl_fsm;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic        start_i;
   logic [2:0]  in_ready_start_i;
   logic [0:0]  out_ready_start_i;
   logic [2:0]  in_req_start_o;
   logic [0:0]  out_req_start_o;
   logic        engine_ready_i;
   logic [31:0] engine_cnt_i;
   logic [31:0] cnt_limit_i;
   logic        engine_start_o;
   logic        engine_clear_o;
   logic        engine_enable_o;
   logic        ucode_valid_i;
   logic        ucode_done_i;
   logic        ucode_enable_o;
   logic        ucode_clear_o;
   logic        done_o;
   logic        busy_o;
   logic [15:0] iter_cnt_o;
   logic        error_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   hwpe_stream_ctrl_fsm #(
      .N_IN(3), .N_OUT(1), .CNT_W(32), .ITER_W(16), .TIMEOUT_CYC(10)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .in_ready_start_i(in_ready_start_i), .out_ready_start_i(out_ready_start_i),
      .in_req_start_o(in_req_start_o), .out_req_start_o(out_req_start_o),
      .engine_ready_i(engine_ready_i), .engine_cnt_i(engine_cnt_i),
      .cnt_limit_i(cnt_limit_i), .engine_start_o(engine_start_o),
      .engine_clear_o(engine_clear_o), .engine_enable_o(engine_enable_o),
      .ucode_valid_i(ucode_valid_i), .ucode_done_i(ucode_done_i),
      .ucode_enable_o(ucode_enable_o), .ucode_clear_o(ucode_clear_o),
      .done_o(done_o), .busy_o(busy_o), .iter_cnt_o(iter_cnt_o),
      .error_o(error_o)
   );

   typedef struct {
      logic        st;
      logic [2:0]  ir;
      logic        orr;
      logic [31:0] cnt;
      logic [31:0] lim;
      logic        uv;
      logic        ud;
      logic        clr;
      logic [2:0]  ireq;
      logic        oreq;
      logic        es;
      logic        ec;
      logic        ee;
      logic        ue;
      logic        uc;
      logic        dn;
      logic        bz;
      logic [15:0] it;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input int st, input int ir, input int orr, input int cnt, input int lim,
      input int uv, input int ud, input int clr, input int ireq, input int oreq,
      input int es, input int ec, input int ee, input int ue, input int uc,
      input int dn, input int bz, input int it);
      vec_t v;
      v.st = st[0]; v.ir = ir[2:0]; v.orr = orr[0];
      v.cnt = cnt; v.lim = lim; v.uv = uv[0]; v.ud = ud[0]; v.clr = clr[0];
      v.ireq = ireq[2:0]; v.oreq = oreq[0]; v.es = es[0]; v.ec = ec[0];
      v.ee = ee[0]; v.ue = ue[0]; v.uc = uc[0]; v.dn = dn[0]; v.bz = bz[0];
      v.it = it[15:0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drv(input logic st, input logic [2:0] ir, input logic orr,
                      input int cnt, input int lim, input logic uv,
                      input logic ud, input logic clr);
      start_i = st; in_ready_start_i = ir; out_ready_start_i = orr;
      engine_cnt_i = cnt; cnt_limit_i = lim;
      ucode_valid_i = uv; ucode_done_i = ud; clear_i = clr;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Job 1: single iteration, limit 4
      //        st ir orr cnt lim uv ud clr ireq oreq es ec ee ue uc dn bz it
      tbl.push_back(mk(1, 7, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 7, 1, 0, 4, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 7, 1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 4, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 4, 4, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 4, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
      // Job 2: three iterations, limit 8
      tbl.push_back(mk(1, 7, 1, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 7, 1, 0, 8, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 8, 8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 8, 8, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 8, 1, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 8, 8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 8, 8, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 2));
      tbl.push_back(mk(0, 7, 1, 0, 8, 1, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1, 2));
      tbl.push_back(mk(0, 7, 1, 8, 8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 2));
      tbl.push_back(mk(0, 7, 1, 8, 8, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 3));
      tbl.push_back(mk(0, 7, 1, 0, 8, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 3));
      tbl.push_back(mk(0, 7, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
      tbl.push_back(mk(0, 7, 1, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3));
      // Job 3: partial ready -> WAIT, limit 0, ucode_valid late, sink stall
      tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3));
      tbl.push_back(mk(0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 5, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
      // Job 4: clear in COMPUTE at cnt=2, then clean restart
      tbl.push_back(mk(1, 7, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 7, 1, 0, 4, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 2, 4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 2, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 7, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 7, 1, 0, 4, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 4, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 7, 1, 4, 4, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 4, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 7, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));

      rst_ni = 1'b0;
      engine_ready_i = 1'b1;
      drv(0, 3'b111, 1, 0, 4, 0, 0, 0);
      #12;
      chk("rst_busy", busy_o, 0);
      chk("rst_eclr", engine_clear_o, 1);
      chk("rst_uclr", ucode_clear_o, 1);
      chk("rst_iter", iter_cnt_o, 0);
      chk("rst_req", {in_req_start_o, out_req_start_o}, 0);
      rst_ni = 1'b1;
      step();

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         logic [31:0] got, exp;
         v = tbl[i];
         drv(v.st, v.ir, v.orr, v.cnt, v.lim, v.uv, v.ud, v.clr);
         @(negedge clk_i);
         got = {in_req_start_o, out_req_start_o, engine_start_o,
                engine_clear_o, engine_enable_o, ucode_enable_o,
                ucode_clear_o, done_o, busy_o, error_o, iter_cnt_o};
         exp = {v.ireq, v.oreq, v.es, v.ec, v.ee, v.ue, v.uc,
                v.dn, v.bz, 1'b0, v.it};
         chk($sformatf("vec%0d", i), got, exp);
         step();
      end

      // Async reset while in UPDATEIDX
      drv(1, 3'b111, 1, 0, 4, 0, 0, 0);
      step();
      drv(0, 3'b111, 1, 0, 4, 0, 0, 0);
      step();
      drv(0, 3'b111, 1, 4, 4, 0, 0, 0);
      step();
      @(negedge clk_i);
      chk("upd_entry_uen", ucode_enable_o, 1);
      chk("upd_iter", iter_cnt_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_eclr", engine_clear_o, 1);
      chk("arst_uclr", ucode_clear_o, 1);
      chk("arst_iter", iter_cnt_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

`ifdef HWPE_FSM_WATCHDOG_EN
      begin
         int k;
         logic seen_done;
         drv(1, 3'b111, 1, 0, 0, 0, 0, 0);
         step();
         drv(0, 3'b111, 1, 0, 0, 0, 0, 0);
         step();
         step();
         step();
         drv(0, 3'b111, 1, 0, 0, 1, 1, 0);
         step();
         drv(0, 3'b111, 0, 0, 0, 0, 0, 0);
         k = 0;
         seen_done = 1'b0;
         @(negedge clk_i);
         while (!error_o && k < 20) begin
            if (done_o) seen_done = 1'b1;
            step();
            @(negedge clk_i);
            k++;
         end
         chk("wd_cycles", k, 10);
         chk("wd_err", error_o, 1);
         chk("wd_done", done_o | seen_done, 0);
         step();
         @(negedge clk_i);
         chk("wd_idle", busy_o, 0);
         chk("wd_err_pulse", error_o, 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
